riscv_mc_core: RTL and testbench
================================

# riscv_mc_core

Multicycle RV32I-subset processor core: the CPU of the `riscv_machine` top level, between a combinational-read instruction memory and a data memory whose read data, write data and write enable each pass through 4 register stages. The core fetches one instruction per step, executes most instructions in one clock, and stretches loads and stores to cover the data-memory pipeline latency. It raises `halted` on ECALL/EBREAK; the top level ends simulation on that signal.

## Interface
No parameters.
- `clk` input 1: single clock, rising-edge.
- `rst_b` input 1: asynchronous, active-low reset.
- `inst` input 32: instruction word at `inst_addr`; byte 0 = bits 7:0. Valid in the same cycle (combinational).
- `inst_addr` output 32: PC.
- `mem_addr` output 32: data byte address (word-aligned use).
- `mem_data_out` input 4×8: read bytes, lane 0 = LSB, delayed 4 clocks relative to `mem_addr`.
- `mem_data_in` output 4×8: store bytes, lane 0 = LSB.
- `mem_write_en` output 1: store strobe.
- `halted` output 1: sticky halt flag.

## Operation
- State: PC, 32×32 register file (x0 reads 0, writes ignored), FSM {EXEC, MEM}, 3-bit wait counter, halt flag.
- Supported instructions, all other encodings execute as NOPs (PC+4):
  - LUI, AUIPC, JAL, JALR (target bit 0 cleared).
  - BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI.
  - ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA.
  - LW, SW; ECALL/EBREAK.
- Arithmetic: 32-bit wrap-around; shifts use low 5 bits of the amount; immediates sign-extended per RV32I.
- EXEC:
  - Decode `inst`, read registers, compute result.
  - Non-memory instruction: rd and PC update at the clock edge; stay in EXEC.
- LW/SW in EXEC:
  - At the edge, register `mem_addr` = rs1+imm; SW also registers `mem_data_in` = rs2 and sets `mem_write_en`=1.
  - Clear the counter and enter MEM. PC is unchanged.
- MEM:
  - Hold `mem_addr` and `mem_data_in`.
  - `mem_write_en` is 1 only in the first MEM cycle, then 0.
  - Counter increments each cycle.
  - At the end of the 5th MEM cycle (counter==4): LW writes rd = {lane3,lane2,lane1,lane0} of `mem_data_out`; PC += 4; return to EXEC.
- ECALL (0x00000073) / EBREAK (0x00100073): set `halted`. From then on PC, registers and memory outputs freeze until reset.
- Misaligned LW/SW addresses are passed through unmodified; the memory defines the behaviour.

## Timing
- Reset (async, `rst_b`=0) sets all of the following to 0 immediately: PC, all registers, FSM=EXEC, counter, `mem_addr`, `mem_data_in`, `mem_write_en`, `halted`.
- First fetch occurs at address 0 in the first cycle after release.
- Latency:
  - Non-memory instruction: 1 cycle.
  - LW/SW: 6 cycles (1 EXEC + 5 MEM).
- Store alignment:
  - The strobe issued in MEM cycle 1 reaches the memory in MEM cycle 5.
  - `mem_addr` is still held then, so the write lands at the correct address on the edge ending MEM cycle 5.
- Load data:
  - Data driven for `mem_addr` in MEM cycle 1 is valid at `mem_data_out` in MEM cycle 5.
  - It is sampled on that edge.
- Back-to-back SW then LW to the same address returns the new value: the write completes before the LW's EXEC cycle.
- Outside MEM, `mem_write_en`=0 and `mem_addr` keeps its last value.
- `halted` rises on the edge ending ECALL's EXEC cycle and stays high.
- Reset asserted mid-MEM aborts the access.
  - The write strobe may still be in the external delay line.
  - The external delay registers are also reset, so no write occurs.

## Test plan
- Reset, then `addi x1,x0,5`; `addi x2,x1,-7` → x1=5, x2=0xFFFFFFFE; PC=8 after 2 cycles.
- `lui x3,0x12345`; `addi x3,x3,0x678`; `sw x3,16(x0)`; `lw x4,16(x0)` → x4=0x12345678; `mem_write_en` high exactly 1 cycle; LW takes 6 cycles.
- Branches, with x1=1, x2=-1:
  - `blt x2,x1,+8` → taken, PC+8.
  - `bltu x2,x1,+8` → not taken, PC+4.
  - `jal x5,+12` → x5=PC+4, PC=PC+12.
- `addi x0,x0,9` → x0 stays 0. Shifts with x1=0x80000000:
  - `srai x6,x1,31` → 0xFFFFFFFF.
  - `srli x7,x1,31` → 1.
- `ecall` → `halted`=1 next cycle; PC and registers frozen for 10 further cycles.
- Assert `rst_b`=0 during MEM cycle 3 of an SW to address 32 → memory word 32 unchanged; PC=0; all outputs 0.

Source files
------------

// File: rtl/riscv_mc_core_if.sv
// Instruction-fetch and data-memory bus between riscv_mc_core and its memories.
// The core drives the master side; the memory model drives the slave side.
interface riscv_mc_core_if;
    logic [31:0]     inst;
    logic [31:0]     inst_addr;
    logic [31:0]     mem_addr;
    logic [3:0][7:0] mem_data_out;
    logic [3:0][7:0] mem_data_in;
    logic            mem_write_en;

    modport master (
        input  inst, mem_data_out,
        output inst_addr, mem_addr, mem_data_in, mem_write_en
    );

    modport slave (
        output inst, mem_data_out,
        input  inst_addr, mem_addr, mem_data_in, mem_write_en
    );
endinterface

// File: rtl/riscv_mc_core.sv
// Multicycle RV32I-subset core: one EXEC cycle per instruction, loads and stores
// stretched by five MEM cycles to cover the 4-stage data-memory pipeline.
module riscv_mc_core (
    input  logic                   clk,
    input  logic                   rst_b,
    riscv_mc_core_if.master        bus,
    output logic                   halted,
    output logic                   o_dbg_state,
    output logic [2:0]             o_dbg_cnt,
    input  logic [4:0]             i_dbg_rsel,
    output logic [31:0]            o_dbg_rdata
);
    typedef enum logic {S_EXEC = 1'b0, S_MEM = 1'b1} state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_regs [32];
    logic [2:0]  r_cnt;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_mem_we;
    logic        r_halted;

    logic [31:0] w_inst;
    logic [6:0]  w_op;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_rs1v, w_rs2v;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_pc_plus4;

    assign w_inst  = bus.inst;
    assign w_op    = w_inst[6:0];
    assign w_rd    = w_inst[11:7];
    assign w_f3    = w_inst[14:12];
    assign w_rs1   = w_inst[19:15];
    assign w_rs2   = w_inst[24:20];
    assign w_f7    = w_inst[31:25];
    assign w_rs1v  = r_regs[w_rs1];
    assign w_rs2v  = r_regs[w_rs2];
    assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
    assign w_imm_s = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
    assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_imm_u = {w_inst[31:12], 12'b0};
    assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
    assign w_pc_plus4 = r_pc + 32'd4;

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  alu = alt ? (a - b) : (a + b);
            3'b001:  alu = a << b[4:0];
            3'b010:  alu = {31'b0, $signed(a) < $signed(b)};
            3'b011:  alu = {31'b0, a < b};
            3'b100:  alu = a ^ b;
            3'b101:  alu = alt ? $unsigned($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110:  alu = a | b;
            default: alu = a & b;
        endcase
    endfunction

    logic w_taken;
    always_comb begin
        w_taken = 1'b0;
        case (w_f3)
            3'b000:  w_taken = (w_rs1v == w_rs2v);
            3'b001:  w_taken = (w_rs1v != w_rs2v);
            3'b100:  w_taken = ($signed(w_rs1v) <  $signed(w_rs2v));
            3'b101:  w_taken = ($signed(w_rs1v) >= $signed(w_rs2v));
            3'b110:  w_taken = (w_rs1v <  w_rs2v);
            3'b111:  w_taken = (w_rs1v >= w_rs2v);
            default: w_taken = 1'b0;
        endcase
    end

    logic        w_wb_en, w_is_load, w_is_store, w_is_halt;
    logic [31:0] w_wb_val, w_next_pc, w_mem_ea;

    always_comb begin
        w_wb_en    = 1'b0;
        w_wb_val   = 32'd0;
        w_next_pc  = w_pc_plus4;
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_is_halt  = 1'b0;
        w_mem_ea   = w_rs1v + w_imm_i;
        case (w_op)
            OP_LUI:    begin w_wb_en = 1'b1; w_wb_val = w_imm_u; end
            OP_AUIPC:  begin w_wb_en = 1'b1; w_wb_val = r_pc + w_imm_u; end
            OP_JAL:    begin w_wb_en = 1'b1; w_wb_val = w_pc_plus4; w_next_pc = r_pc + w_imm_j; end
            OP_JALR: begin
                if (w_f3 == 3'b000) begin
                    w_wb_en   = 1'b1;
                    w_wb_val  = w_pc_plus4;
                    w_next_pc = (w_rs1v + w_imm_i) & ~32'd1;
                end
            end
            OP_BRANCH: if (w_taken) w_next_pc = r_pc + w_imm_b;
            OP_IMM: begin
                // Shift-immediates carry their funct7 in the immediate field; bad ones are NOPs.
                if ((w_f3 == 3'b001 && w_f7 == 7'b0000000) ||
                    (w_f3 == 3'b101 && (w_f7 == 7'b0000000 || w_f7 == 7'b0100000)) ||
                    (w_f3 != 3'b001 && w_f3 != 3'b101)) begin
                    w_wb_en  = 1'b1;
                    w_wb_val = alu(w_f3, (w_f3 == 3'b101) && w_inst[30], w_rs1v, w_imm_i);
                end
            end
            OP_REG: begin
                if (w_f7 == 7'b0000000 ||
                    (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101))) begin
                    w_wb_en  = 1'b1;
                    w_wb_val = alu(w_f3, w_inst[30], w_rs1v, w_rs2v);
                end
            end
            OP_LOAD:   w_is_load = (w_f3 == 3'b010);
            OP_STORE: begin
                w_is_store = (w_f3 == 3'b010);
                w_mem_ea   = w_rs1v + w_imm_s;
            end
            OP_SYSTEM: w_is_halt = (w_inst == 32'h00000073) || (w_inst == 32'h00100073);
            default: ;
        endcase
    end

    // PC is held through MEM, so the load's rd is still decodable from inst there.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state     <= S_EXEC;
            r_pc        <= 32'd0;
            r_cnt       <= 3'd0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_we    <= 1'b0;
            r_halted    <= 1'b0;
            for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
        end else if (!r_halted) begin
            case (r_state)
                S_EXEC: begin
                    if (w_is_halt) begin
                        r_halted <= 1'b1;
                    end else if (w_is_load || w_is_store) begin
                        r_mem_addr <= w_mem_ea;
                        if (w_is_store) begin
                            r_mem_wdata <= w_rs2v;
                            r_mem_we    <= 1'b1;
                        end
                        r_cnt   <= 3'd0;
                        r_state <= S_MEM;
                    end else begin
                        if (w_wb_en && w_rd != 5'd0) r_regs[w_rd] <= w_wb_val;
                        r_pc <= w_next_pc;
                    end
                end
                S_MEM: begin
                    r_mem_we <= 1'b0;
                    r_cnt    <= r_cnt + 3'd1;
                    if (r_cnt == 3'd4) begin
                        if (w_is_load && w_rd != 5'd0) r_regs[w_rd] <= bus.mem_data_out;
                        r_pc    <= w_pc_plus4;
                        r_state <= S_EXEC;
                    end
                end
                default: r_state <= S_EXEC;
            endcase
        end
    end

    assign bus.inst_addr    = r_pc;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_data_in  = r_mem_wdata;
    assign bus.mem_write_en = r_mem_we;
    assign halted           = r_halted;
    assign o_dbg_state      = r_state;
    assign o_dbg_cnt        = r_cnt;
    assign o_dbg_rdata      = r_regs[i_dbg_rsel];
endmodule

// File: tb/tb_riscv_mc_core.sv
// Directed bench for riscv_mc_core: combinational instruction memory plus a data
// memory whose read data, write data and write enable each pass through 4 registers.
module tb_riscv_mc_core;
    logic        clk;
    logic        rst_b;
    logic        halted;
    logic        dbg_state;
    logic [2:0]  dbg_cnt;
    logic [4:0]  dbg_sel;
    logic [31:0] dbg_rdata;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    riscv_mc_core_if bus ();

    riscv_mc_core dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .bus         (bus.master),
        .halted      (halted),
        .o_dbg_state (dbg_state),
        .o_dbg_cnt   (dbg_cnt),
        .i_dbg_rsel  (dbg_sel),
        .o_dbg_rdata (dbg_rdata)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // instruction memory
    logic [31:0] imem [256];
    assign bus.inst = imem[bus.inst_addr[9:2]];

    // data memory with external delay line
    logic [31:0] dmem [64];
    logic [3:0]  we_d;
    logic [31:0] wd_d [4];
    logic [31:0] rd_d [4];
    logic        bk_we;
    logic [5:0]  bk_idx;
    logic [31:0] bk_data;

    assign bus.mem_data_out = rd_d[3];

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            we_d <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                wd_d[i] <= 32'd0;
                rd_d[i] <= 32'd0;
            end
        end else begin
            we_d    <= {we_d[2:0], bus.mem_write_en};
            wd_d[0] <= bus.mem_data_in;
            rd_d[0] <= dmem[bus.mem_addr[7:2]];
            for (int i = 1; i < 4; i++) begin
                wd_d[i] <= wd_d[i-1];
                rd_d[i] <= rd_d[i-1];
            end
        end
    end

    always @(posedge clk) begin
        if (bk_we) dmem[bk_idx] <= bk_data;
        else if (we_d[3]) dmem[bus.mem_addr[7:2]] <= wd_d[3];
    end

    // instruction encoders
    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(input int imm20, input int rd, input int op);
        return {imm20[19:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_j(input int imm, input int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction

    // driver tasks
    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 32'h00000013;
    endtask

    task automatic begin_reset();
        @(negedge clk);
        rst_b = 1'b0;
    endtask

    task automatic end_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic backdoor_write(input logic [5:0] idx, input logic [31:0] data);
        @(negedge clk);
        bk_idx  = idx;
        bk_data = data;
        bk_we   = 1'b1;
        @(negedge clk);
        bk_we   = 1'b0;
    endtask

    // scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_reg(input string tag, input int n, input logic [31:0] exp);
        dbg_sel = n[4:0];
        #1;
        check(tag, dbg_rdata, exp);
    endtask

    int we_cnt;

    initial begin
        rst_b   = 1'b0;
        bk_we   = 1'b0;
        bk_idx  = 6'd0;
        bk_data = 32'd0;
        dbg_sel = 5'd0;
        clear_imem();

        // ADDI pair
        imem[0] = enc_i(5, 0, 0, 1, 7'h13);
        imem[1] = enc_i(-7, 1, 0, 2, 7'h13);
        end_reset();
        #1;
        check("rst_pc", bus.inst_addr, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_we", 32'(bus.mem_write_en), 32'd0);
        check("rst_addr", bus.mem_addr, 32'd0);
        check_reg("rst_x1", 1, 32'd0);
        run(2);
        check("addi_pc", bus.inst_addr, 32'd8);
        check_reg("addi_x1", 1, 32'd5);
        check_reg("addi_x2", 2, 32'hFFFFFFFE);

        // SW then LW
        begin_reset();
        clear_imem();
        imem[0] = enc_u(20'h12345, 3, 7'h37);
        imem[1] = enc_i(12'h678, 3, 0, 3, 7'h13);
        imem[2] = enc_s(16, 3, 0);
        imem[3] = enc_i(16, 0, 2, 4, 7'h03);
        exp_q.push_back(32'h12345678);
        end_reset();
        run(2);
        check("lui_pc", bus.inst_addr, 32'd8);
        check_reg("lui_addi_x3", 3, 32'h12345678);
        run(1);
        check("sw_we_mem1", 32'(bus.mem_write_en), 32'd1);
        check("sw_addr", bus.mem_addr, 32'd16);
        check("sw_data", bus.mem_data_in, 32'h12345678);
        check("sw_state", 32'(dbg_state), 32'd1);
        check("sw_pc_hold", bus.inst_addr, 32'd8);
        we_cnt = 1;
        for (int i = 0; i < 5; i++) begin
            run(1);
            we_cnt += int'(bus.mem_write_en);
        end
        check("sw_we_cycles", 32'(we_cnt), 32'd1);
        check("sw_pc_done", bus.inst_addr, 32'd12);
        check("sw_dmem", dmem[4], 32'h12345678);
        run(5);
        check("lw_pc_hold", bus.inst_addr, 32'd12);
        check("lw_cnt", 32'(dbg_cnt), 32'd4);
        check_reg("lw_x4_pending", 4, 32'd0);
        run(1);
        check("lw_pc_done", bus.inst_addr, 32'd16);
        check("lw_state", 32'(dbg_state), 32'd0);
        check_reg("lw_x4", 4, exp_q.pop_front());

        // branches, JAL, register ops
        begin_reset();
        clear_imem();
        imem[0]  = enc_i(1, 0, 0, 1, 7'h13);
        imem[1]  = enc_i(-1, 0, 0, 2, 7'h13);
        imem[2]  = enc_b(8, 1, 2, 3'b100);
        imem[3]  = enc_i(1, 0, 0, 10, 7'h13);
        imem[4]  = enc_b(8, 1, 2, 3'b110);
        imem[5]  = enc_j(12, 5);
        imem[6]  = enc_i(2, 0, 0, 10, 7'h13);
        imem[7]  = enc_i(3, 0, 0, 10, 7'h13);
        imem[8]  = enc_r(7'h20, 2, 1, 0, 9);
        imem[9]  = enc_r(7'h00, 1, 2, 2, 11);
        end_reset();
        run(3);
        check("blt_taken_pc", bus.inst_addr, 32'd16);
        run(1);
        check("bltu_not_taken_pc", bus.inst_addr, 32'd20);
        run(1);
        check("jal_pc", bus.inst_addr, 32'd32);
        check_reg("jal_x5", 5, 32'd24);
        check_reg("skipped_x10", 10, 32'd0);
        run(2);
        check("rop_pc", bus.inst_addr, 32'd40);
        check_reg("sub_x9", 9, 32'd2);
        check_reg("slt_x11", 11, 32'd1);

        // x0, shifts, ECALL
        begin_reset();
        clear_imem();
        imem[0] = enc_i(9, 0, 0, 0, 7'h13);
        imem[1] = enc_u(20'h80000, 1, 7'h37);
        imem[2] = enc_i(12'h41F, 1, 5, 6, 7'h13);
        imem[3] = enc_i(31, 1, 5, 7, 7'h13);
        imem[4] = 32'h00000073;
        imem[5] = enc_i(3, 0, 0, 8, 7'h13);
        end_reset();
        run(4);
        check("shift_pc", bus.inst_addr, 32'd16);
        check("pre_halt", 32'(halted), 32'd0);
        check_reg("x0_zero", 0, 32'd0);
        check_reg("srai_x6", 6, 32'hFFFFFFFF);
        check_reg("srli_x7", 7, 32'd1);
        run(1);
        check("ecall_halted", 32'(halted), 32'd1);
        check("ecall_pc", bus.inst_addr, 32'd16);
        run(10);
        check("frozen_halted", 32'(halted), 32'd1);
        check("frozen_pc", bus.inst_addr, 32'd16);
        check_reg("frozen_x8", 8, 32'd0);
        check_reg("frozen_x6", 6, 32'hFFFFFFFF);

        // reset during MEM cycle 3 of a store to address 32
        begin_reset();
        clear_imem();
        imem[0] = enc_i(12'h055, 0, 0, 1, 7'h13);
        imem[1] = enc_s(32, 1, 0);
        backdoor_write(6'd8, 32'hA5A5A5A5);
        backdoor_write(6'd0, 32'h0BADF00D);
        end_reset();
        run(4);
        check("abort_state", 32'(dbg_state), 32'd1);
        check("abort_cnt", 32'(dbg_cnt), 32'd2);
        rst_b = 1'b0;
        #1;
        check("abort_pc", bus.inst_addr, 32'd0);
        check("abort_addr", bus.mem_addr, 32'd0);
        check("abort_data", bus.mem_data_in, 32'd0);
        check("abort_we", 32'(bus.mem_write_en), 32'd0);
        check("abort_halted", 32'(halted), 32'd0);
        check_reg("abort_x1", 1, 32'd0);
        clear_imem();
        end_reset();
        run(8);
        check("abort_dmem32", dmem[8], 32'hA5A5A5A5);
        check("abort_dmem0", dmem[0], 32'h0BADF00D);
        check("abort_nop_pc", bus.inst_addr, 32'd32);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
